// File: rtl/lsu.sv
// lsu: rv32i load/store unit; one byte/halfword/word access in flight, FSM IDLE->REQ->WAIT->RESP.
// Latency: 3 cycles accept->response on an immediate bus; illegal access responds 1 cycle after accept.
// Backpressure: req_ready_o only in IDLE; bus stalls are bounded by TIMEOUT_CYCLES; response is not stallable.
// Optional: define LSU_MISALIGN_TRAP_EN to trap misaligned halfword/word accesses instead of masking low bits.
module lsu #(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid_i,
    output logic        req_ready_o,
    input  logic        req_we_i,
    input  logic [2:0]  req_funct3_i,
    input  logic [31:0] addr_i,
    input  logic [31:0] wdata_i,
    input  logic [4:0]  rd_i,
    output logic        mem_valid_o,
    input  logic        mem_ready_i,
    output logic        mem_we_o,
    output logic [31:0] mem_addr_o,
    output logic [3:0]  mem_be_o,
    output logic [31:0] mem_wdata_o,
    input  logic        mem_rvalid_i,
    input  logic [31:0] mem_rdata_i,
    output logic        resp_valid_o,
    output logic [31:0] resp_rdata_o,
    output logic [4:0]  resp_rd_o,
    output logic        resp_err_o
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_WAIT = 2'd2,
        S_RESP = 2'd3
    } state_t;

    // Last counter value before the transaction is abandoned.
    localparam logic [15:0] TO_LAST = 16'(TIMEOUT_CYCLES - 1);

    state_t      state;
    state_t      state_nxt;

    // Captured access attributes needed after the bus request is issued.
    logic [2:0]  cap_f3;
    logic [1:0]  cap_off;
    logic [4:0]  cap_rd;

    logic [15:0] to_cnt;
    logic        timeout;

    // Decode of the incoming request.
    logic        req_funct_bad;
    logic        req_illegal;
    logic [1:0]  req_off;
    logic [3:0]  req_be;
    logic [31:0] req_wdata;

    // Load alignment/extension of the returned word.
    logic [7:0]  ld_byte;
    logic [15:0] ld_half;
    logic [31:0] ld_data;

    // Ready only in IDLE and never while reset is held.
    assign req_ready_o = rst_n && (state == S_IDLE);

    assign timeout = ((state == S_REQ) || (state == S_WAIT)) && (to_cnt == TO_LAST);

    // Request legality, effective lane offset, byte enables and lane-replicated store data.
    always_comb begin
        req_funct_bad = 1'b0;
        req_off       = addr_i[1:0];
        req_be        = 4'b1111;
        req_wdata     = 32'd0;
        req_illegal   = 1'b0;

        // Stores accept only 0..2; loads reject 3, 6 and 7.
        if (req_we_i) begin
            req_funct_bad = (req_funct3_i > 3'd2);
        end else begin
            req_funct_bad = (req_funct3_i[1:0] == 2'd3) || (req_funct3_i[2:1] == 2'b11);
        end

        // Low address bits below the access size never select a lane.
        case (req_funct3_i[1:0])
            2'd1:    req_off = {addr_i[1], 1'b0};
            2'd2:    req_off = 2'b00;
            default: req_off = addr_i[1:0];
        endcase

`ifdef LSU_MISALIGN_TRAP_EN
        case (req_funct3_i[1:0])
            2'd1:    req_illegal = req_funct_bad || addr_i[0];
            2'd2:    req_illegal = req_funct_bad || (addr_i[1:0] != 2'b00);
            default: req_illegal = req_funct_bad;
        endcase
`else
        req_illegal = req_funct_bad;
`endif

        case (req_funct3_i[1:0])
            2'd0:    req_be = 4'b0001 << req_off;
            2'd1:    req_be = req_off[1] ? 4'b1100 : 4'b0011;
            default: req_be = 4'b1111;
        endcase

        if (req_we_i) begin
            case (req_funct3_i[1:0])
                2'd0:    req_wdata = {4{wdata_i[7:0]}};
                2'd1:    req_wdata = {2{wdata_i[15:0]}};
                default: req_wdata = wdata_i;
            endcase
        end
    end

    // Select the addressed byte/halfword of the read word and extend per funct3.
    always_comb begin
        ld_byte = 8'd0;
        ld_half = 16'd0;
        ld_data = 32'd0;

        case (cap_off)
            2'd0:    ld_byte = mem_rdata_i[7:0];
            2'd1:    ld_byte = mem_rdata_i[15:8];
            2'd2:    ld_byte = mem_rdata_i[23:16];
            default: ld_byte = mem_rdata_i[31:24];
        endcase

        ld_half = cap_off[1] ? mem_rdata_i[31:16] : mem_rdata_i[15:0];

        case (cap_f3)
            3'd0:    ld_data = {{24{ld_byte[7]}}, ld_byte};
            3'd1:    ld_data = {{16{ld_half[15]}}, ld_half};
            3'd4:    ld_data = {24'd0, ld_byte};
            3'd5:    ld_data = {16'd0, ld_half};
            default: ld_data = mem_rdata_i;
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic; in REQ the bus handshake wins over a same-cycle rvalid and over timeout.
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (req_valid_i) begin
                    state_nxt = req_illegal ? S_RESP : S_REQ;
                end
            end
            S_REQ: begin
                if (mem_ready_i) begin
                    state_nxt = S_WAIT;
                end else if (timeout) begin
                    state_nxt = S_RESP;
                end
            end
            S_WAIT: begin
                if (mem_rvalid_i || timeout) begin
                    state_nxt = S_RESP;
                end
            end
            S_RESP: begin
                state_nxt = S_IDLE;
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    // Bus timeout counter: cleared when the request is issued, counts every REQ/WAIT cycle.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            to_cnt <= 16'd0;
        end else if (state == S_IDLE) begin
            to_cnt <= 16'd0;
        end else if ((state == S_REQ) || (state == S_WAIT)) begin
            to_cnt <= to_cnt + 16'd1;
        end
    end

    // Registered bus request, captured attributes and response outputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            mem_valid_o  <= 1'b0;
            mem_we_o     <= 1'b0;
            mem_addr_o   <= 32'd0;
            mem_be_o     <= 4'd0;
            mem_wdata_o  <= 32'd0;
            resp_valid_o <= 1'b0;
            resp_rdata_o <= 32'd0;
            resp_rd_o    <= 5'd0;
            resp_err_o   <= 1'b0;
            cap_f3       <= 3'd0;
            cap_off      <= 2'd0;
            cap_rd       <= 5'd0;
        end else begin
            resp_valid_o <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (req_valid_i) begin
                        cap_f3  <= req_funct3_i;
                        cap_off <= req_off;
                        cap_rd  <= rd_i;
                        if (req_illegal) begin
                            resp_valid_o <= 1'b1;
                            resp_err_o   <= 1'b1;
                            resp_rdata_o <= 32'd0;
                            resp_rd_o    <= rd_i;
                        end else begin
                            mem_valid_o <= 1'b1;
                            mem_we_o    <= req_we_i;
                            mem_addr_o  <= {addr_i[31:2], 2'b00};
                            mem_be_o    <= req_be;
                            mem_wdata_o <= req_wdata;
                        end
                    end
                end
                S_REQ: begin
                    if (mem_ready_i) begin
                        mem_valid_o <= 1'b0;
                    end else if (timeout) begin
                        mem_valid_o  <= 1'b0;
                        resp_valid_o <= 1'b1;
                        resp_err_o   <= 1'b1;
                        resp_rdata_o <= 32'd0;
                        resp_rd_o    <= cap_rd;
                    end
                end
                S_WAIT: begin
                    if (mem_rvalid_i) begin
                        resp_valid_o <= 1'b1;
                        resp_err_o   <= 1'b0;
                        resp_rdata_o <= mem_we_o ? 32'd0 : ld_data;
                        resp_rd_o    <= cap_rd;
                    end else if (timeout) begin
                        resp_valid_o <= 1'b1;
                        resp_err_o   <= 1'b1;
                        resp_rdata_o <= 32'd0;
                        resp_rd_o    <= cap_rd;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: doc/lsu.md
# lsu

Load/store unit of the rv32i execute stage. It takes the effective address computed by the ALU (rs1 + imm) together with the store data and funct3, and performs one byte, halfword or word access on the data-memory port. It returns the aligned and extended load data, or a store acknowledgement, to writeback. It has one transaction in flight at a time and is built around a 4-state FSM with a bus-timeout counter.

## Interface
Parameters:
- TIMEOUT_CYCLES, 255: number of cycles spent in REQ+WAIT before the transaction is aborted with an error. Range 1..65535.

Ports:
- clk  in  1  core clock; all logic on the rising edge
- rst_n  in  1  **one clock; reset is synchronous and active-low**
- req_valid_i  in  1  execute stage presents an access
- req_ready_o  out  1  unit can accept an access (IDLE only)
- req_we_i  in  1  1 = store, 0 = load
- req_funct3_i  in  3  LB=0, LH=1, LW=2, LBU=4, LHU=5; SB=0, SH=1, SW=2
- addr_i  in  32  effective address (ALU result)
- wdata_i  in  32  store data (rs2)
- rd_i  in  5  destination register, returned with the response
- mem_valid_o  out  1  bus request
- mem_ready_i  in  1  bus accepts the request
- mem_we_o  out  1  write strobe
- mem_addr_o  out  32  word address, bits [1:0] = 0
- mem_be_o  out  4  byte enables
- mem_wdata_o  out  32  lane-replicated store data
- mem_rvalid_i  in  1  bus response (read data or write ack)
- mem_rdata_i  in  32  read word
- resp_valid_o  out  1  one-cycle completion pulse; no backpressure
- resp_rdata_o  out  32  extended load data; 0 for stores and errors
- resp_rd_o  out  5  captured rd_i
- resp_err_o  out  1  access error (illegal funct3, misaligned, timeout)

## Operation
- States are IDLE, REQ, WAIT and RESP. The outputs and transitions in each state are:
  - IDLE: req_ready_o=1. On req_valid_i, capture we, funct3, addr, wdata and rd. Go to REQ, or go straight to RESP with error when the access is illegal.
  - REQ: mem_valid_o=1, with all mem_* outputs held stable. On mem_ready_i, go to WAIT.
  - WAIT: on mem_rvalid_i, latch and extend the read data, then go to RESP.
  - RESP: resp_valid_o=1 for exactly one cycle, then go to IDLE.
- The following funct3 values are illegal and produce an error: 3, 6 and 7 for loads; 3 to 7 for stores. An illegal access generates no bus activity, and gives resp_err_o=1 with resp_rdata_o=0.
- Byte enables and store data:
  - SB: mem_be_o = 1 << addr[1:0]; store byte replicated into all 4 lanes.
  - SH: mem_be_o = 0011 when addr[1]=0, 1100 when addr[1]=1; store halfword replicated into both halves.
  - SW: mem_be_o = 1111.
- For loads, mem_we_o=0 and mem_be_o carries the same pattern as the matching store.
- Load extraction:
  - Byte lane selected by addr[1:0]; halfword selected by addr[1].
  - LB and LH are sign-extended; LBU and LHU are zero-extended.
- Timeout counter:
  - Cleared on entry to REQ; increments every cycle in REQ or WAIT.
  - Reaching TIMEOUT_CYCLES forces RESP with err=1 and rdata=0, and mem_valid_o drops.
  - A later mem_rvalid_i arriving outside WAIT is ignored.
- When mem_ready_i and mem_rvalid_i arrive in the same cycle while in REQ, only mem_ready_i is honoured. The bus responds no earlier than the cycle after acceptance.

## Timing
- Reset values: mem_valid_o=0, mem_we_o=0, mem_addr_o=0, mem_be_o=0, mem_wdata_o=0, resp_valid_o=0, resp_rdata_o=0, resp_rd_o=0, resp_err_o=0, state=IDLE.
- While rst_n=0, req_ready_o=0. It reads 1 from the first cycle after reset is released.
- All outputs except req_ready_o are registered.
- Nominal cycle sequence:
  - Cycle T: request accepted.
  - T+1: mem_valid_o high.
  - mem_ready_i at T+1: WAIT at T+2.
  - mem_rvalid_i at T+2: resp_valid_o at T+3.
- Minimum latency is 3 cycles from acceptance to response. An illegal access responds at T+1.
- Back-to-back throughput is one access per 4 cycles minimum, because req_ready_o is 0 in RESP.
- Reset mid-operation: the FSM is in IDLE and mem_valid_o=0 after the edge. The transaction is abandoned with no response.

## Configuration
- LSU_MISALIGN_TRAP_EN defined:
  - An access is misaligned when it is LH/LHU/SH with addr[0]=1, or LW/SW with addr[1:0]≠0.
  - A misaligned access goes IDLE→RESP with err=1 and makes no bus request.
- Undefined:
  - Low address bits are ignored for access sizes above a byte: addr[0] is treated as 0 for halfwords, and addr[1:0] as 0 for words.
  - The access proceeds with err=0.

## Test plan
- LW at 0x1000, memory returns 0xDEADBEEF with ready at T+1 and rvalid at T+2: resp_valid_o at T+3, rdata=0xDEADBEEF, err=0, rd echoed.
- LB at 0x1003 returns word 0x80FF_FF00: rdata=0xFFFFFF80. LBU at the same address: rdata=0x00000080. LHU at 0x1002: rdata=0x000080FF.
- SB at 0x2001 with wdata=0x000000A5: mem_be_o=0010, mem_wdata_o=0xA5A5A5A5, mem_we_o=1. Response has rdata=0 and err=0.
- LW at 0x1002:
  - With LSU_MISALIGN_TRAP_EN: resp at T+1 with err=1 and no mem_valid_o.
  - Without it: mem_addr_o=0x1000, err=0.
- TIMEOUT_CYCLES=4 with mem_ready_i stuck at 0: mem_valid_o high for 4 cycles, then err=1 and rdata=0. A late rvalid in IDLE is ignored.
- rst_n=0 asserted while in WAIT: next cycle mem_valid_o=0 and resp_valid_o=0. After release, a new LW completes normally.
